dp_mem_unit: RTL and testbench
==============================

DP_MEM_UNIT -- requirements
Module: dp_mem_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 10, meaning address port width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning number of words, with DEPTH <= 2^ADDR_SIZE.
REQ-004 The block SHALL have parameter INIT_FILE, default "" (none), meaning binary image loaded by $readmemb at elaboration when non-empty.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-007 The block SHALL have ports W1 and W2, input, WIDTH bits each, meaning write data for ports 1 and 2.
REQ-008 The block SHALL have ports A1 and A2, input, ADDR_SIZE bits each, meaning addresses for ports 1 and 2.
REQ-009 The block SHALL have ports Write1, Write2, Read1 and Read2, input, 1 bit each, meaning per-port write and read requests.
REQ-010 The block SHALL have port Clear, input, 1 bit, meaning a request to zero the whole array.
REQ-011 The block SHALL have ports R1 and R2, output, WIDTH bits each, meaning registered read data.
REQ-012 The block SHALL have ports Valid1 and Valid2, output, 1 bit each, meaning R1/R2 were updated this cycle.
REQ-013 The block SHALL have port Ready, output, 1 bit, meaning requests are being accepted.
REQ-014 The block SHALL have port Collision, output, 1 bit, meaning a same-address dual write was seen the previous cycle.

Function
REQ-015 The block SHALL have two states: IDLE (Ready=1) and CLEAR (Ready=0).
REQ-016 In IDLE, Read on a port at edge N SHALL load R with mem[A] and set Valid=1 for the cycle after edge N.
- Read latency: 1 cycle.
- No read: R holds its value, Valid=0.
REQ-017 In IDLE, Write on a port SHALL store W at mem[A] at the edge.
REQ-018 When Write1 and Write2 target the same address, port 1 data SHALL be stored and Collision SHALL pulse high for exactly one cycle.
REQ-019 Without bypass, a read of an address written at the same edge by either port SHALL return the old contents (read-first).
REQ-020 An address >= DEPTH SHALL be handled as follows:
- Write: dropped, no state change.
- Read: R=0, Valid=1.
REQ-021 Clear in IDLE SHALL enter CLEAR and zero one word per cycle, address 0 to DEPTH-1, with the counter ADDR_SIZE+1 bits wide so it cannot wrap.
REQ-022 After the final word (DEPTH cycles), the block SHALL return to IDLE; Ready rises on the following cycle.
REQ-023 In CLEAR, the block SHALL behave as follows:
- All Read/Write requests and any further Clear: ignored.
- Valid1, Valid2 and Collision: 0.
- R1/R2: hold their values.
REQ-024 Clear asserted together with port requests in IDLE SHALL take priority; the port requests on that edge are ignored.

Reset
REQ-025 While reset=1, the outputs SHALL be R1=0, R2=0, Valid1=0, Valid2=0, Collision=0, Ready=1; state IDLE; clear counter 0.
REQ-026 Reset SHALL NOT modify array contents; reset during CLEAR aborts it, leaving the array partially cleared.

Configuration
REQ-027 With MEM_BYPASS_EN defined, a read of an address written at the same edge, on either port, SHALL return the newly written data (write-first); for a dual-write collision it returns W1.
REQ-028 With MEM_BYPASS_EN undefined, the block SHALL behave read-first per REQ-019.

Verification
REQ-029 Write1 A1=5 W1=16'hBEEF, then Read2 A2=5 next cycle -> R2=BEEF, Valid2=1 one cycle later.
REQ-030 Write1 A1=7 W1=1111 and Write2 A2=7 W2=2222 same edge -> mem[7]=1111, Collision=1 for one cycle.
REQ-031 mem[3]=AAAA; Write1 A1=3 W1=5555 with Read2 A2=3 same edge -> R2=AAAA (no bypass) / 5555 (MEM_BYPASS_EN).
REQ-032 DEPTH=1000; Write1 A1=1010, then Read1 A1=1010 -> R1=0, Valid1=1, no other word changed.
REQ-033 Fill mem, pulse Clear -> Ready=0 for 1024 cycles, Write1 during CLEAR ignored; afterwards Read of 0 and 1023 returns 0.
REQ-034 Assert reset 10 cycles into CLEAR -> Ready=1 immediately, words 0-9 zero, word 10 retains its prior value.

Source files
------------

// File: rtl/dp_mem_unit.sv
// Dual-port word memory with registered reads, a same-address write collision flag and a sequential clear.
// Optional feature: define MEM_BYPASS_EN for write-first same-edge read data (default build is read-first).
module dp_mem_unit #(
  parameter int WIDTH     = 16,
  parameter int ADDR_SIZE = 10,
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     W1,
  input  logic [WIDTH-1:0]     W2,
  input  logic [ADDR_SIZE-1:0] A1,
  input  logic [ADDR_SIZE-1:0] A2,
  input  logic                 Write1,
  input  logic                 Write2,
  input  logic                 Read1,
  input  logic                 Read2,
  input  logic                 Clear,
  output logic [WIDTH-1:0]     R1,
  output logic [WIDTH-1:0]     R2,
  output logic                 Valid1,
  output logic                 Valid2,
  output logic                 Ready,
  output logic                 Collision
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] LAST_C  = (ADDR_SIZE+1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE:0]   clrCnt_q, clrCnt_d;
  logic [WIDTH-1:0]     r1_q, r1_d, r2_q, r2_d;
  logic                 valid1_q, valid1_d, valid2_q, valid2_d;
  logic                 collision_q, collision_d;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 inRange1, inRange2, accept;
  logic [IDX_W-1:0]     idx1, idx2, clrIdx;
  logic [WIDTH-1:0]     rdData1, rdData2;

  assign inRange1 = {1'b0, A1} < DEPTH_C;
  assign inRange2 = {1'b0, A2} < DEPTH_C;
  assign idx1     = A1[IDX_W-1:0];
  assign idx2     = A2[IDX_W-1:0];
  assign clrIdx   = clrCnt_q[IDX_W-1:0];
  assign accept   = (state_q == IDLE) && !Clear;

  // Port 1 is written last so it wins a same-address dual write.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clrIdx] <= '0;
    end else if (!Clear) begin
      if (Write2 && inRange2) mem[idx2] <= W2;
      if (Write1 && inRange1) mem[idx1] <= W1;
    end
  end

  always_comb begin
    rdData1 = inRange1 ? mem[idx1] : '0;
    rdData2 = inRange2 ? mem[idx2] : '0;
`ifdef MEM_BYPASS_EN
    if (inRange1) begin
      if (Write1)                 rdData1 = W1;
      else if (Write2 && A2 == A1) rdData1 = W2;
    end
    if (inRange2) begin
      if (Write1 && A1 == A2)     rdData2 = W1;
      else if (Write2)            rdData2 = W2;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    clrCnt_d    = clrCnt_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    valid1_d    = 1'b0;
    valid2_d    = 1'b0;
    collision_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Clear) begin
          state_d  = CLEAR;
          clrCnt_d = '0;
        end else if (accept) begin
          if (Read1) begin
            r1_d     = rdData1;
            valid1_d = 1'b1;
          end
          if (Read2) begin
            r2_d     = rdData2;
            valid2_d = 1'b1;
          end
          collision_d = Write1 && Write2 && (A1 == A2);
        end
      end
      CLEAR: begin
        if (clrCnt_q == LAST_C) begin
          state_d  = IDLE;
          clrCnt_d = '0;
        end else begin
          clrCnt_d = clrCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves the array untouched; an in-progress clear is simply abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clrCnt_q    <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      valid1_q    <= 1'b0;
      valid2_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrCnt_q    <= clrCnt_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      valid1_q    <= valid1_d;
      valid2_q    <= valid2_d;
      collision_q <= collision_d;
    end
  end

  assign R1        = r1_q;
  assign R2        = r2_q;
  assign Valid1    = valid1_q;
  assign Valid2    = valid2_q;
  assign Collision = collision_q;
  assign Ready     = (state_q == IDLE);

endmodule

// File: tb/tb_dp_mem_unit.sv
// Directed self-checking bench for dp_mem_unit: vector table plus clear, out-of-range and reset-abort sequences.
module tb_dp_mem_unit;

`ifdef MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, reset;
  logic [15:0] W1, W2;
  logic [9:0]  A1, A2;
  logic        Write1, Write2, Read1, Read2, Clear;
  logic [15:0] R1, R2, R1s, R2s;
  logic        Valid1, Valid2, Ready, Collision;
  logic        Valid1s, Valid2s, Readys, Collisions;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        w1, w2, r1, r2;
    logic [9:0]  a1, a2;
    logic [15:0] d1, d2;
    logic [15:0] eR1, eR2;
    logic        eV1, eV2, eCol;
  } vec_t;

  vec_t vecs[$];

  dp_mem_unit dut (
    .clk(clk), .reset(reset), .W1(W1), .W2(W2), .A1(A1), .A2(A2),
    .Write1(Write1), .Write2(Write2), .Read1(Read1), .Read2(Read2), .Clear(Clear),
    .R1(R1), .R2(R2), .Valid1(Valid1), .Valid2(Valid2), .Ready(Ready), .Collision(Collision)
  );

  dp_mem_unit #(.WIDTH(16), .ADDR_SIZE(10), .DEPTH(1000)) dutSmall (
    .clk(clk), .reset(reset), .W1(W1), .W2(W2), .A1(A1), .A2(A2),
    .Write1(Write1), .Write2(Write2), .Read1(Read1), .Read2(Read2), .Clear(Clear),
    .R1(R1s), .R2(R2s), .Valid1(Valid1s), .Valid2(Valid2s), .Ready(Readys), .Collision(Collisions)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    Write1 = 0; Write2 = 0; Read1 = 0; Read2 = 0; Clear = 0;
  endtask

  task automatic addVec(input logic w1, w2, r1, r2, input logic [9:0] a1, a2,
                        input logic [15:0] d1, d2, eR1, eR2, input logic eV1, eV2, eCol);
    vec_t v;
    v = '{w1: w1, w2: w2, r1: r1, r2: r2, a1: a1, a2: a2, d1: d1, d2: d2,
          eR1: eR1, eR2: eR2, eV1: eV1, eV2: eV2, eCol: eCol};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    Write1 = v.w1; Write2 = v.w2; Read1 = v.r1; Read2 = v.r2;
    A1 = v.a1; A2 = v.a2; W1 = v.d1; W2 = v.d2; Clear = 0;
    tick();
    idleInputs();
  endtask

  task automatic writeWord(input logic [9:0] addr, input logic [15:0] data);
    Write1 = 1; A1 = addr; W1 = data;
    tick();
    idleInputs();
  endtask

  task automatic readWord(input logic [9:0] addr);
    Read1 = 1; A1 = addr;
    tick();
    idleInputs();
  endtask

  initial begin
    int lowCycles;
    bit done;

    // w1 w2 r1 r2  a1  a2  d1       d2       eR1      eR2      eV1 eV2 eCol
    addVec(1, 0, 0, 0, 5,  0,  16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    addVec(0, 0, 0, 1, 0,  5,  16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 0, 1, 0);
    addVec(1, 1, 0, 0, 7,  7,  16'h1111, 16'h2222, 16'h0000, 16'hBEEF, 0, 0, 1);
    addVec(0, 0, 1, 0, 7,  0,  16'h0000, 16'h0000, 16'h1111, 16'hBEEF, 1, 0, 0);
    addVec(1, 0, 0, 0, 3,  0,  16'hAAAA, 16'h0000, 16'h1111, 16'hBEEF, 0, 0, 0);
    addVec(1, 0, 0, 1, 3,  3,  16'h5555, 16'h0000, 16'h1111, BYP ? 16'h5555 : 16'hAAAA, 0, 1, 0);
    addVec(0, 0, 1, 1, 3,  7,  16'h0000, 16'h0000, 16'h5555, 16'h1111, 1, 1, 0);
    addVec(0, 1, 1, 0, 3,  3,  16'h0000, 16'h0F0F, BYP ? 16'h0F0F : 16'h5555, 16'h1111, 1, 0, 0);
    addVec(0, 0, 0, 0, 0,  0,  16'h0000, 16'h0000, BYP ? 16'h0F0F : 16'h5555, 16'h1111, 0, 0, 0);
    addVec(0, 0, 1, 1, 3,  5,  16'h0000, 16'h0000, 16'h0F0F, 16'hBEEF, 1, 1, 0);
    addVec(1, 1, 0, 0, 20, 21, 16'h0001, 16'h0002, 16'h0F0F, 16'hBEEF, 0, 0, 0);
    addVec(0, 0, 1, 1, 21, 20, 16'h0000, 16'h0000, 16'h0002, 16'h0001, 1, 1, 0);

    idleInputs();
    A1 = 0; A2 = 0; W1 = 0; W2 = 0;
    reset = 1;
    tick();
    tick();
    checkOutput("reset R1", R1, 0);
    checkOutput("reset R2", R2, 0);
    checkOutput("reset Valid1", Valid1, 0);
    checkOutput("reset Valid2", Valid2, 0);
    checkOutput("reset Collision", Collision, 0);
    checkOutput("reset Ready", Ready, 1);
    reset = 0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d R1", i), R1, vecs[i].eR1);
      checkOutput($sformatf("row%0d R2", i), R2, vecs[i].eR2);
      checkOutput($sformatf("row%0d Valid1", i), Valid1, vecs[i].eV1);
      checkOutput($sformatf("row%0d Valid2", i), Valid2, vecs[i].eV2);
      checkOutput($sformatf("row%0d Collision", i), Collision, vecs[i].eCol);
      checkOutput($sformatf("row%0d Ready", i), Ready, 1);
    end

    // Clear wins over simultaneous port requests, then runs for DEPTH cycles
    Clear = 1; Write1 = 1; A1 = 5; W1 = 16'hDEAD; Read1 = 1;
    tick();
    idleInputs();
    checkOutput("clear start Ready", Ready, 0);
    checkOutput("clear start Valid1", Valid1, 0);
    checkOutput("clear start R1 hold", R1, 16'h0002);
    lowCycles = 1;
    done = 0;
    for (int it = 0; it < 2000 && !done; it++) begin
      if (it == 500) begin
        Write1 = 1; A1 = 0; W1 = 16'hFFFF; Read1 = 1; Clear = 1;
      end
      tick();
      if (it == 500) begin
        checkOutput("clear Valid1 ignored", Valid1, 0);
        checkOutput("clear R1 hold", R1, 16'h0002);
        idleInputs();
      end
      if (Ready == 0) lowCycles++;
      else done = 1;
    end
    checkOutput("clear Ready-low cycles", lowCycles, 1024);
    readWord(0);
    checkOutput("after clear word0", R1, 0);
    checkOutput("after clear Valid1", Valid1, 1);
    readWord(1023);
    checkOutput("after clear word1023", R1, 0);
    readWord(5);
    checkOutput("after clear word5", R1, 0);

    // Out-of-range access on the DEPTH=1000 instance
    writeWord(1010, 16'h1234);
    readWord(1010);
    checkOutput("oor R1", R1s, 0);
    checkOutput("oor Valid1", Valid1s, 1);
    checkOutput("in-range 1010 big R1", R1, 16'h1234);
    readWord(10);
    checkOutput("oor alias word10", R1s, 0);
    readWord(498);
    checkOutput("oor alias word498", R1s, 0);
    readWord(999);
    checkOutput("oor alias word999", R1s, 0);

    // Reset ten cycles into a clear aborts it part way
    writeWord(0, 16'h0001);
    writeWord(9, 16'h0999);
    writeWord(10, 16'h0ABC);
    readWord(10);
    Clear = 1;
    tick();
    idleInputs();
    repeat (10) tick();
    checkOutput("abort pre-reset Ready", Ready, 0);
    reset = 1;
    #1;
    checkOutput("abort Ready immediate", Ready, 1);
    checkOutput("abort R1 zero", R1, 0);
    @(negedge clk);
    reset = 0;
    readWord(9);
    checkOutput("abort word9", R1, 0);
    readWord(10);
    checkOutput("abort word10", R1, 16'h0ABC);
    readWord(0);
    checkOutput("abort word0", R1, 0);
    checkOutput("abort Ready after", Ready, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
